// File: rtl/cam_tcam_if.sv
// cam_tcam_if: bus interface for the ternary CAM.
//
// Carries the read, write, invalidate and search requests into the CAM, and
// the registered read and search results back out.
//   master modport : request side (drives the *_i signals, observes the *_o signals)
//   slave modport  : CAM side (observes the *_i signals, drives the *_o signals)
// Parameters:
//   DATA_WIDTH  : width of keys, masks and search data
//   INDEX_WIDTH : width of every entry index
interface cam_tcam_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_WIDTH = 4
);

  logic                   read_i;
  logic [INDEX_WIDTH-1:0] read_index_i;
  logic                   write_i;
  logic [INDEX_WIDTH-1:0] write_index_i;
  logic [DATA_WIDTH-1:0]  write_data_i;
  logic [DATA_WIDTH-1:0]  write_mask_i;
  logic                   invalidate_i;
  logic [INDEX_WIDTH-1:0] invalidate_index_i;
  logic                   search_i;
  logic [DATA_WIDTH-1:0]  search_data_i;

  logic                   read_valid_o;
  logic [DATA_WIDTH-1:0]  read_value_o;
  logic [DATA_WIDTH-1:0]  read_mask_o;
  logic                   search_valid_o;
  logic [INDEX_WIDTH-1:0] search_index_o;
  logic                   search_multi_o;
  logic                   search_miss_o;

  modport master (
    output read_i, read_index_i,
    output write_i, write_index_i, write_data_i, write_mask_i,
    output invalidate_i, invalidate_index_i,
    output search_i, search_data_i,
    input  read_valid_o, read_value_o, read_mask_o,
    input  search_valid_o, search_index_o, search_multi_o, search_miss_o
  );

  modport slave (
    input  read_i, read_index_i,
    input  write_i, write_index_i, write_data_i, write_mask_i,
    input  invalidate_i, invalidate_index_i,
    input  search_i, search_data_i,
    output read_valid_o, read_value_o, read_mask_o,
    output search_valid_o, search_index_o, search_multi_o, search_miss_o
  );

endinterface

// File: rtl/cam_tcam.sv
// cam_tcam: parametrised ternary content-addressable memory.
//
// Each entry holds a key, a care mask (1 = bit compared, 0 = don't-care) and
// a valid bit. Searches run through a two-stage pipeline: stage 1 registers
// the per-entry match vector, and stage 2 priority-encodes the lowest
// matching index and flags a multi-hit or a miss. The result appears two
// cycles after search_i, and a new search is accepted every cycle.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : asynchronous, active-low reset (clears valid bits, outputs, pipeline)
//   bus   : cam_tcam_if slave modport (read/write/invalidate/search requests
//           and the read/search results)
module cam_tcam #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int INDEX_WIDTH = $clog2(DEPTH)
) (
  input logic        clk,
  input logic        reset,
  cam_tcam_if.slave  bus
);

  logic [DATA_WIDTH-1:0]  key_mem  [DEPTH];
  logic [DATA_WIDTH-1:0]  mask_mem [DEPTH];
  logic [DEPTH-1:0]       valid_q;

  logic [DEPTH-1:0]       match;
  logic                   s1_valid;
  logic [DEPTH-1:0]       s1_match;

  logic [INDEX_WIDTH-1:0] enc_index;
  logic                   enc_hit;
  logic                   enc_multi;

  // Key and mask storage carries no reset; the valid bit alone decides
  // whether an entry takes part in reads and searches.
  always_ff @(posedge clk) begin
    if (bus.write_i) begin
      key_mem[bus.write_index_i]  <= bus.write_data_i;
      mask_mem[bus.write_index_i] <= bus.write_mask_i;
    end
  end

  // Invalidate is applied after write, so it wins when both target the
  // same entry in one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
    end else begin
      if (bus.write_i) begin
        valid_q[bus.write_index_i] <= 1'b1;
      end
      if (bus.invalidate_i) begin
        valid_q[bus.invalidate_index_i] <= 1'b0;
      end
    end
  end

  // The read port samples the pre-write state. Value and mask hold while
  // no read is requested.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.read_valid_o <= 1'b0;
      bus.read_value_o <= '0;
      bus.read_mask_o  <= '0;
    end else begin
      bus.read_valid_o <= bus.read_i & valid_q[bus.read_index_i];
      if (bus.read_i) begin
        bus.read_value_o <= key_mem[bus.read_index_i];
        bus.read_mask_o  <= mask_mem[bus.read_index_i];
      end
    end
  end

  // Ternary compare: only bits with the mask set have to agree.
  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = valid_q[i] &&
                 (((bus.search_data_i ^ key_mem[i]) & mask_mem[i]) == '0);
    end
  end

  // Stage 1 register. The match vector is cleared when there is no search,
  // so an idle stage never carries a stale match into stage 2.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_match <= '0;
    end else begin
      s1_valid <= bus.search_i;
      s1_match <= bus.search_i ? match : '0;
    end
  end

  // Priority encoder. The loop runs from the top index down, so the lowest
  // set bit is the last one assigned. Clearing the lowest set bit leaves
  // something non-zero exactly when two or more entries matched.
  always_comb begin
    enc_index = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (s1_match[i]) begin
        enc_index = INDEX_WIDTH'(i);
      end
    end
    enc_hit   = |s1_match;
    enc_multi = (s1_match & (s1_match - DEPTH'(1))) != '0;
  end

  // Stage 2 register. Exactly one of valid or miss pulses per search. The
  // index only updates on a hit, so it holds across misses and idle cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.search_valid_o <= 1'b0;
      bus.search_miss_o  <= 1'b0;
      bus.search_multi_o <= 1'b0;
      bus.search_index_o <= '0;
    end else begin
      bus.search_valid_o <= s1_valid & enc_hit;
      bus.search_miss_o  <= s1_valid & ~enc_hit;
      bus.search_multi_o <= s1_valid & enc_multi;
      if (s1_valid && enc_hit) begin
        bus.search_index_o <= enc_index;
      end
    end
  end

endmodule

// File: tb/tb_cam_tcam.sv
// tb_cam_tcam: self-checking testbench for cam_tcam.
//
// A behavioural model (arrays of key/mask/valid plus a one-deep result
// delay) predicts every output cycle by cycle. Directed sequences cover
// reset, basic hits, ternary multi-hit, invalidate, back-to-back searches
// and reset while a search is in flight. A randomized phase follows.
module tb_cam_tcam;

  localparam int DW  = 32;
  localparam int DEP = 16;
  localparam int IW  = 4;

  logic clk;
  logic reset;

  cam_tcam_if #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW)) bus ();

  cam_tcam #(.DATA_WIDTH(DW), .DEPTH(DEP), .INDEX_WIDTH(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vec_count;
  int miscompare_count;

  logic [DW-1:0] m_key   [DEP];
  logic [DW-1:0] m_mask  [DEP];
  bit            m_valid [DEP];

  logic          e_rv;
  logic [DW-1:0] e_rval;
  logic [DW-1:0] e_rmask;
  logic          e_sv;
  logic          e_smiss;
  logic          e_smulti;
  logic [IW-1:0] e_sidx;

  logic          p_valid;
  logic          p_hit;
  logic          p_multi;
  logic [IW-1:0] p_idx;

  logic [DW-1:0] key_pool [4];

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    vec_count++;
    if (obs !== exp) begin
      miscompare_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compares every DUT output against the model's current expectation.
  task automatic checkAll();
    checkOutput("read_valid", 64'(bus.read_valid_o), 64'(e_rv));
    if (e_rv) begin
      checkOutput("read_value", 64'(bus.read_value_o), 64'(e_rval));
      checkOutput("read_mask", 64'(bus.read_mask_o), 64'(e_rmask));
    end
    checkOutput("search_valid", 64'(bus.search_valid_o), 64'(e_sv));
    checkOutput("search_miss", 64'(bus.search_miss_o), 64'(e_smiss));
    checkOutput("search_multi", 64'(bus.search_multi_o), 64'(e_smulti));
    checkOutput("search_index", 64'(bus.search_index_o), 64'(e_sidx));
  endtask

  task automatic modelReset();
    for (int i = 0; i < DEP; i++) begin
      m_valid[i] = 1'b0;
      m_key[i]   = '0;
      m_mask[i]  = '0;
    end
    e_rv = 1'b0; e_rval = '0; e_rmask = '0;
    e_sv = 1'b0; e_smiss = 1'b0; e_smulti = 1'b0; e_sidx = '0;
    p_valid = 1'b0; p_hit = 1'b0; p_multi = 1'b0; p_idx = '0;
  endtask

  task automatic setIdle();
    bus.read_i = 1'b0;       bus.read_index_i = '0;
    bus.write_i = 1'b0;      bus.write_index_i = '0;
    bus.write_data_i = '0;   bus.write_mask_i = '0;
    bus.invalidate_i = 1'b0; bus.invalidate_index_i = '0;
    bus.search_i = 1'b0;     bus.search_data_i = '0;
  endtask

  // One clock with the inputs currently on the bus. The model predicts the
  // outputs from pre-edge state, then applies the write and the invalidate
  // (invalidate last, so it wins on the same index).
  task automatic runCycle();
    int            hits;
    logic          cur_valid;
    logic [IW-1:0] cur_idx;
    cur_valid = bus.search_i;
    hits      = 0;
    cur_idx   = '0;
    if (cur_valid) begin
      for (int i = 0; i < DEP; i++) begin
        if (m_valid[i] && (((bus.search_data_i ^ m_key[i]) & m_mask[i]) == '0)) begin
          if (hits == 0) cur_idx = IW'(i);
          hits++;
        end
      end
    end
    if (bus.read_i) begin
      e_rv    = m_valid[bus.read_index_i];
      e_rval  = m_key[bus.read_index_i];
      e_rmask = m_mask[bus.read_index_i];
    end else begin
      e_rv = 1'b0;
    end
    @(posedge clk);
    #1;
    e_sv     = p_valid && p_hit;
    e_smiss  = p_valid && !p_hit;
    e_smulti = p_valid && p_multi;
    if (p_valid && p_hit) e_sidx = p_idx;
    p_valid = cur_valid;
    p_hit   = hits > 0;
    p_multi = hits > 1;
    p_idx   = cur_idx;
    if (bus.write_i) begin
      m_key[bus.write_index_i]   = bus.write_data_i;
      m_mask[bus.write_index_i]  = bus.write_mask_i;
      m_valid[bus.write_index_i] = 1'b1;
    end
    if (bus.invalidate_i) m_valid[bus.invalidate_index_i] = 1'b0;
    checkAll();
  endtask

  task automatic applyStimulus(input logic rd, input logic [IW-1:0] ridx,
                               input logic wr, input logic [IW-1:0] widx,
                               input logic [DW-1:0] wdata, input logic [DW-1:0] wmask,
                               input logic inv, input logic [IW-1:0] iidx,
                               input logic srch, input logic [DW-1:0] sdata);
    bus.read_i = rd;        bus.read_index_i = ridx;
    bus.write_i = wr;       bus.write_index_i = widx;
    bus.write_data_i = wdata; bus.write_mask_i = wmask;
    bus.invalidate_i = inv; bus.invalidate_index_i = iidx;
    bus.search_i = srch;    bus.search_data_i = sdata;
    runCycle();
  endtask

  task automatic doWrite(input logic [IW-1:0] idx, input logic [DW-1:0] k,
                         input logic [DW-1:0] m);
    applyStimulus(1'b0, '0, 1'b1, idx, k, m, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic doSearch(input logic [DW-1:0] sdata);
    applyStimulus(1'b0, '0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b1, sdata);
  endtask

  task automatic doRead(input logic [IW-1:0] idx);
    applyStimulus(1'b1, idx, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic doIdle();
    setIdle();
    runCycle();
  endtask

  task automatic applyReset();
    setIdle();
    reset = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkAll();
    reset = 1'b1;
  endtask

  initial begin
    vec_count        = 0;
    miscompare_count = 0;
    key_pool[0] = 32'hCAFE_F00D;
    key_pool[1] = 32'h1234_5678;
    key_pool[2] = 32'h0000_FFFF;
    key_pool[3] = 32'hA5A5_5A5A;
    setIdle();
    applyReset();

    // 1: empty CAM misses, read of an unwritten entry is invalid.
    doSearch(32'h0000_0000);
    doRead(4'd3);
    checkOutput("t1_miss", 64'(bus.search_miss_o), 64'd1);
    checkOutput("t1_valid", 64'(bus.search_valid_o), 64'd0);
    checkOutput("t1_read_valid", 64'(bus.read_valid_o), 64'd0);

    // 2: exact-match entry at index 5.
    doWrite(4'd5, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    doSearch(32'hDEAD_BEEF);
    doRead(4'd5);
    checkOutput("t2_valid", 64'(bus.search_valid_o), 64'd1);
    checkOutput("t2_index", 64'(bus.search_index_o), 64'd5);
    checkOutput("t2_multi", 64'(bus.search_multi_o), 64'd0);
    checkOutput("t2_read_value", 64'(bus.read_value_o), 64'hDEAD_BEEF);

    // 3: masked entry 2 and exact entry 7 both match; lowest index wins.
    doWrite(4'd2, 32'h1234_0000, 32'hFFFF_0000);
    doWrite(4'd7, 32'h1234_5678, 32'hFFFF_FFFF);
    doSearch(32'h1234_5678);
    doSearch(32'h1234_9999);
    checkOutput("t3_index", 64'(bus.search_index_o), 64'd2);
    checkOutput("t3_multi", 64'(bus.search_multi_o), 64'd1);
    doIdle();
    checkOutput("t3b_index", 64'(bus.search_index_o), 64'd2);
    checkOutput("t3b_multi", 64'(bus.search_multi_o), 64'd0);

    // 4: invalidate, then a same-cycle write and invalidate of one entry.
    applyStimulus(1'b0, '0, 1'b0, '0, '0, '0, 1'b1, 4'd2, 1'b0, '0);
    doSearch(32'h1234_5678);
    doIdle();
    checkOutput("t4_index", 64'(bus.search_index_o), 64'd7);
    checkOutput("t4_multi", 64'(bus.search_multi_o), 64'd0);
    applyStimulus(1'b0, '0, 1'b1, 4'd7, 32'h1234_5678, 32'hFFFF_FFFF,
                  1'b1, 4'd7, 1'b0, '0);
    doSearch(32'h1234_5678);
    doIdle();
    checkOutput("t4_miss", 64'(bus.search_miss_o), 64'd1);

    // 5: back-to-back searches produce results on consecutive cycles.
    doWrite(4'd7, 32'h1234_5678, 32'hFFFF_FFFF);
    doSearch(32'hDEAD_BEEF);
    doSearch(32'h0BAD_0000);
    checkOutput("t5a_index", 64'(bus.search_index_o), 64'd5);
    doSearch(32'h1234_5678);
    checkOutput("t5b_miss", 64'(bus.search_miss_o), 64'd1);
    doIdle();
    checkOutput("t5c_index", 64'(bus.search_index_o), 64'd7);
    checkOutput("t5c_valid", 64'(bus.search_valid_o), 64'd1);
    doIdle();

    // 6: reset while a search is in flight drops it and clears all entries.
    doSearch(32'hDEAD_BEEF);
    setIdle();
    reset = 1'b0;
    modelReset();
    #1;
    checkAll();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) doIdle();
    for (int i = 0; i < DEP; i++) doRead(IW'(i));
    doSearch(32'hDEAD_BEEF);
    doIdle();
    checkOutput("t6_miss", 64'(bus.search_miss_o), 64'd1);

    // Randomized traffic from a small key pool so hits and multi-hits occur.
    for (int n = 0; n < 400; n++) begin
      logic [DW-1:0] k;
      logic [DW-1:0] msk;
      logic [DW-1:0] sd;
      int            sel;
      k   = key_pool[$urandom_range(0, 3)];
      sel = int'($urandom_range(0, 7));
      if (sel <= 4)      msk = '1;
      else if (sel == 5) msk = '0;
      else if (sel == 6) msk = 32'hFFFF_0000;
      else               msk = $urandom;
      sd = key_pool[$urandom_range(0, 3)];
      if ($urandom_range(0, 3) == 0) sd = sd ^ $urandom;
      applyStimulus(1'($urandom_range(0, 1)), IW'($urandom_range(0, DEP - 1)),
                    1'($urandom_range(0, 3) == 0), IW'($urandom_range(0, DEP - 1)),
                    k, msk,
                    1'($urandom_range(0, 5) == 0), IW'($urandom_range(0, DEP - 1)),
                    1'($urandom_range(0, 2) != 0), sd);
    end
    doIdle();
    doIdle();

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare_count);
    $finish;
  end

endmodule

// File: doc/cam_tcam.md
Name: cam_tcam

Overview:
Parametrised ternary content-addressable memory. It is the successor to the fixed binary CAM and sits in the same bench/DUT interface environment.
- Adds per-entry care masks, per-entry valid bits and explicit invalidate.
- Search is a two-stage pipeline: stage 1 compares, stage 2 priority-encodes.
- Search reports the lowest matching index plus multi-hit and miss indications.

Parameters:
DATA_WIDTH, 32, width of stored keys, masks and search data
DEPTH, 16, number of entries; power of two, >= 2
INDEX_WIDTH, $clog2(DEPTH), width of every index port

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
read_i  input  1  read request
read_index_i  input  INDEX_WIDTH  entry to read
write_i  input  1  write request
write_index_i  input  INDEX_WIDTH  entry to write
write_data_i  input  DATA_WIDTH  key to store
write_mask_i  input  DATA_WIDTH  care mask; 1 = bit compared, 0 = don't-care
invalidate_i  input  1  clear valid bit of one entry
invalidate_index_i  input  INDEX_WIDTH  entry to invalidate
search_i  input  1  search request, accepted every cycle
search_data_i  input  DATA_WIDTH  search key
read_valid_o  output  1  read data valid (entry was valid)
read_value_o  output  DATA_WIDTH  stored key of read entry
read_mask_o  output  DATA_WIDTH  stored mask of read entry
search_valid_o  output  1  search completed with at least one hit
search_index_o  output  INDEX_WIDTH  lowest matching index
search_multi_o  output  1  more than one entry matched
search_miss_o  output  1  search completed with no hit

Behaviour:
Storage and reset:
- Storage is key[DEPTH], mask[DEPTH] and valid[DEPTH].
- reset low clears all valid bits and all outputs to 0, and flushes the search pipeline.
- Key and mask arrays need not be reset.
- Reset mid-search drops any in-flight search; no result is produced after release.

Write:
- Takes effect at the clock edge: key, mask and valid of write_index_i are set.
- Visible to reads and searches issued in the following cycle.

Invalidate:
- Clears valid of invalidate_index_i at the clock edge.
- Same index written and invalidated in one cycle: invalidate wins, entry ends up invalid.
- Different indices in the same cycle: both operations happen.

Read:
- 1-cycle latency. read_valid_o = valid[idx] as sampled before any same-cycle write.
- read_value_o and read_mask_o are registered from the same pre-write state.
- When read_i = 0, read_valid_o = 0 next cycle and value/mask hold.
- Invalid entry: read_valid_o = 0, value/mask are don't-care.

Search match rule:
- Entry i matches when valid[i] and ((search_data_i ^ key[i]) & mask[i]) == 0.
- An all-zero mask matches any key.

Search pipeline:
- Stage 1 registers the DEPTH-bit match vector plus a valid flag, using pre-write state, so a same-cycle write is not seen.
- Stage 2 priority-encodes the lowest set bit and registers the results.
- Latency is 2 cycles from search_i to result; throughput is 1 search per cycle.

Search outputs:
- Exactly one of search_valid_o or search_miss_o pulses for each accepted search; both are 0 in all other cycles.
- search_multi_o = popcount(match) > 1, qualified by search_valid_o.
- search_index_o holds its last value on miss or when idle.

Write-after-search:
- A write in the cycle after search_i does not affect that search's result, because the compare is already registered.

Concurrency:
- Read, write, invalidate and search are independent and may all be issued in the same cycle.

Test Plan:
1. Reset, then search 0x0000_0000 -> 2 cycles later search_miss_o = 1, search_valid_o = 0. Read index 3 -> read_valid_o = 0.
2. Write idx 5 key 0xDEAD_BEEF mask 0xFFFF_FFFF, then search 0xDEAD_BEEF -> search_valid_o = 1, index 5, multi = 0. Read idx 5 -> valid = 1, value 0xDEAD_BEEF, mask 0xFFFF_FFFF.
3. Write idx 2 key 0x1234_0000 mask 0xFFFF_0000 and idx 7 key 0x1234_5678 full mask, then search 0x1234_5678 -> index 2, multi = 1. Search 0x1234_9999 -> index 2, multi = 0.
4. Invalidate idx 2, then repeat the 0x1234_5678 search -> index 7, multi = 0. Write and invalidate idx 7 in the same cycle -> following search misses.
5. Back-to-back searches A (hit idx 5), B (miss), C (hit idx 7) on consecutive cycles -> results on 3 consecutive cycles in order: valid/5, miss, valid/7.
6. Issue a search, assert reset one cycle later, release -> no search_valid_o or search_miss_o pulse, and all entries invalid.
